// File: rtl/fir_tx_serializer_if.sv
// FIR result / UART byte handshake bundle for fir_tx_serializer.
// slave is the serializer side, master the FIR + transmitter side.
interface fir_tx_if #(
  parameter int OUT_W = 38,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             out_valid;
  logic [OUT_W-1:0] fir_out;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic [LW-1:0]    fifo_level;
  logic             overflow;

  modport master (
    output out_valid, fir_out, tx_busy,
    input  tx_start, tx_data, fifo_level, overflow
  );

  modport slave (
    input  out_valid, fir_out, tx_busy,
    output tx_start, tx_data, fifo_level, overflow
  );
endinterface

// File: rtl/fir_tx_serializer.sv
// Scales FIR results to 16 bits, queues them and sends each one
// to the UART transmitter as two bytes, low byte first.
module fir_tx_serializer #(
  parameter int OUT_W = 38,
  parameter int SHIFT = 8,
  parameter int DEPTH = 4,
  parameter int SAT   = 1
) (
  input logic   clk,
  input logic   rst_n,
  fir_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] START_LO = 3'd1;
  localparam logic [2:0] HOLD_LO  = 3'd2;
  localparam logic [2:0] WAIT_LO  = 3'd3;
  localparam logic [2:0] START_HI = 3'd4;
  localparam logic [2:0] HOLD_HI  = 3'd5;
  localparam logic [2:0] WAIT_HI  = 3'd6;

  logic signed [OUT_W-1:0] s;
  logic [15:0] din;
  logic        hi_clip;
  logic        lo_clip;

  assign s = $signed(bus.fir_out) >>> SHIFT;

  // Out of range when bits above 15 are not all copies of the sign
  assign hi_clip = !s[OUT_W-1] && (|s[OUT_W-2:15]);
  assign lo_clip = s[OUT_W-1] && !(&s[OUT_W-2:15]);

  always_comb begin
    din = s[15:0];
    if (SAT != 0) begin
      if (hi_clip)
        din = 16'h7fff;
      else if (lo_clip)
        din = 16'h8000;
    end
  end

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] level;
  logic          ovf;
  logic          full;
  logic          push;
  logic          pop;

  logic [2:0] state;
  logic [7:0] sample_hi;
  logic [7:0] data_q;

  assign full = level == LW'(DEPTH);
  assign push = bus.out_valid && !full;
  assign pop  = (state == IDLE) && (level != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= din;
    end
  end

  // Fullness uses the registered level, so a pop never frees room
  // for a push on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      if (bus.out_valid && full)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sample_hi <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            sample_hi <= mem[rptr][15:8];
            data_q    <= mem[rptr][7:0];
            state     <= START_LO;
          end
        end
        START_LO: begin
          if (!bus.tx_busy)
            state <= HOLD_LO;
        end
        HOLD_LO:
          state <= WAIT_LO;
        WAIT_LO: begin
          if (!bus.tx_busy) begin
            data_q <= sample_hi;
            state  <= START_HI;
          end
        end
        START_HI: begin
          if (!bus.tx_busy)
            state <= HOLD_HI;
        end
        HOLD_HI:
          state <= WAIT_HI;
        WAIT_HI: begin
          if (!bus.tx_busy)
            state <= IDLE;
        end
        default:
          state <= IDLE;
      endcase
    end
  end

  assign bus.tx_start   = ((state == START_LO) || (state == START_HI))
                          && !bus.tx_busy;
  assign bus.tx_data    = data_q;
  assign bus.fifo_level = level;
  assign bus.overflow   = ovf;
endmodule
